// File: rtl/xadc_frame_collector.sv
// XADC AXI4-Stream sink: offset-binary to two's complement conversion, FWFT sample FIFO,
// and re-framing into fixed-length complex frames with tlast for the FFT input.
module xadc_frame_collector #(
  parameter int unsigned FRAME_LEN = 1024,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        CLK,
  input  logic        resetn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        enable,
  output logic [15:0] frame_count,
  output logic        overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned FW = $clog2(FRAME_LEN);
  localparam logic [FW-1:0] LastIdx  = FW'(FRAME_LEN - 1);
  localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic {StIdle, StCollect} state_e;

  state_e        state_q;
  logic          rst_sync_n;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [FW-1:0] in_cnt_q, out_cnt_q;
  logic [15:0]   frame_count_q;
  logic          overflow_q;

  logic          collecting, fifo_full, fifo_empty;
  logic          wr_en, rd_en, in_last, out_last;
  logic [11:0]   raw_code;
  logic [11:0]   signed_code;
  logic [15:0]   sample_real;
  logic          unused_nibble;

  // Release edge is synchronised; assertion still takes effect immediately.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) rst_sync_n <= 1'b0;
    else         rst_sync_n <= 1'b1;
  end

  assign collecting  = (state_q == StCollect);
  assign fifo_full   = (count_q == DepthCnt);
  assign fifo_empty  = (count_q == '0);
  assign in_last     = (in_cnt_q == LastIdx);
  assign out_last    = (out_cnt_q == LastIdx);

  // Outside COLLECT every word is swallowed so the XADC stream never stalls.
  assign s_axis_tready = !collecting || !fifo_full;
  assign wr_en         = collecting && s_axis_tvalid && !fifo_full;
  assign rd_en         = !fifo_empty && m_axis_tready;

  // Flipping the MSB of an offset-binary code yields the two's complement value.
  assign raw_code      = s_axis_tdata[15:4];
  assign signed_code   = {~raw_code[11], raw_code[10:0]};
  assign sample_real   = {{4{signed_code[11]}}, signed_code};
  assign unused_nibble = ^s_axis_tdata[3:0];

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = {16'h0000, fifo_empty ? 16'h0000 : mem[rd_ptr_q]};
  assign m_axis_tlast  = !fifo_empty && out_last;
  assign frame_count   = frame_count_q;
  assign overflow      = overflow_q;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr_q] <= sample_real;
  end

  // Collection FSM; enable is only looked at in idle and on a frame boundary.
  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state_q  <= StIdle;
      in_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) state_q <= StCollect;
        end
        StCollect: begin
          if (wr_en) begin
            if (in_last) begin
              in_cnt_q <= '0;
              if (!enable) state_q <= StIdle;
            end else begin
              in_cnt_q <= in_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      out_cnt_q     <= '0;
      frame_count_q <= '0;
    end else if (rd_en) begin
      if (out_last) begin
        out_cnt_q     <= '0;
        frame_count_q <= frame_count_q + 1'b1;
      end else begin
        out_cnt_q <= out_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      overflow_q <= 1'b0;
    end else if (collecting && s_axis_tvalid && !s_axis_tready) begin
      overflow_q <= 1'b1;
    end
  end

endmodule
